// File: rtl/tdp_ram_arbiter.sv
// Request front end for a 64x8 true dual-port RAM.
// It resolves same-address collisions with a round-robin stall and returns read data one cycle later.
module tdp_ram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req_a_valid,
  output logic          req_a_ready,
  input  logic          req_a_we,
  input  logic [AW-1:0] req_a_addr,
  input  logic [DW-1:0] req_a_wdata,
  output logic          rsp_a_valid,
  output logic [DW-1:0] rsp_a_rdata,

  input  logic          req_b_valid,
  output logic          req_b_ready,
  input  logic          req_b_we,
  input  logic [AW-1:0] req_b_addr,
  input  logic [DW-1:0] req_b_wdata,
  output logic          rsp_b_valid,
  output logic [DW-1:0] rsp_b_rdata,

  output logic          ram_we_a,
  output logic          ram_we_b,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_a,
  output logic [DW-1:0] ram_data_b,
  input  logic [DW-1:0] ram_q_a,
  input  logic [DW-1:0] ram_q_b,

  output logic [CW-1:0] conflict_cnt
);

  logic conflict;
  logic prio;
  logic accept_a;
  logic accept_b;
  logic rsp_pend_a;
  logic rsp_pend_b;

  // Two reads of one address are harmless; any write on a shared address is a collision.
  assign conflict = req_a_valid & req_b_valid & (req_a_addr == req_b_addr)
                  & (req_a_we | req_b_we);

  // Reset holds both ports off so no write can slip into the RAM while state is cleared.
  assign req_a_ready = ~rst & (~conflict | ~prio);
  assign req_b_ready = ~rst & (~conflict |  prio);

  assign accept_a = req_a_valid & req_a_ready;
  assign accept_b = req_b_valid & req_b_ready;

  assign ram_addr_a = req_a_addr;
  assign ram_addr_b = req_b_addr;
  assign ram_data_a = req_a_wdata;
  assign ram_data_b = req_b_wdata;
  assign ram_we_a   = accept_a & req_a_we;
  assign ram_we_b   = accept_b & req_b_we;

  // A read accepted just before reset must not surface while reset is high.
  assign rsp_a_valid = rsp_pend_a & ~rst;
  assign rsp_b_valid = rsp_pend_b & ~rst;
  assign rsp_a_rdata = ram_q_a;
  assign rsp_b_rdata = ram_q_b;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      prio         <= 1'b0;
      rsp_pend_a   <= 1'b0;
      rsp_pend_b   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      rsp_pend_a <= accept_a & ~req_a_we;
      rsp_pend_b <= accept_b & ~req_b_we;
      if (conflict) begin
        prio <= ~prio;
        if (conflict_cnt != {CW{1'b1}}) begin
          conflict_cnt <= conflict_cnt + CW'(1);
        end
      end
    end
  end

  // The RAM must never see both ports touching one address with a write in the same cycle.
  assert property (@(posedge clk) disable iff (rst)
    !(accept_a && accept_b && (req_a_addr == req_b_addr) && (req_a_we || req_b_we)));

endmodule
